// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage with a two-state data-memory handshake
// and the M/W pipeline register. Upstream stages are held while an access
// is outstanding; the W side receives bubbles during the wait.
// Optional build macro MEM_TIMEOUT_EN: adds an access-timeout counter that
// abandons a stuck access after TIMEOUT_CYCLES wait cycles and pulses MemErr.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic        Cant_ByteM,
    input  logic [4:0]  RDM,
    input  logic [18:0] ALUResultM,
    input  logic [18:0] WriteDataM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [18:0] MemAddr,
    output logic [18:0] MemWData,
    output logic        MemByte,
    input  logic        MemAck,
    input  logic [18:0] MemRData,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RDW,
    output logic [18:0] ALUResultW,
    output logic [18:0] ReadDataW,
    output logic        MemErr
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t state_r;
    logic   mem_op_s;
    logic   req_s;
    logic   stall_s;
    logic   timeout_s;

    // Zero-extend the low byte of a 19-bit word.
    function automatic logic [18:0] zext_byte(input logic [18:0] d);
        return {11'b0, d[7:0]};
    endfunction

    assign mem_op_s = MemWriteM | ResultSrcM;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             mem_err_r;

    // Timeout fires only when no acknowledge arrives in the expiring cycle.
    assign timeout_s = (state_r == WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES)) && !MemAck;

    // Wait-cycle counter: held at zero in IDLE so it is clear on entry to WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_r == IDLE) begin
            wait_cnt_r <= '0;
        end else if (!MemAck && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // One-cycle error pulse following an abandoned access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err_r <= 1'b0;
        end else begin
            mem_err_r <= timeout_s;
        end
    end

    assign MemErr = mem_err_r;
`else
    // No timeout path: the parameter only appears in a constant-false term.
    assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 0);
    assign MemErr    = 1'b0;
`endif

    // Request is a pure function of state and inputs, and reset removes it at once.
    assign req_s   = !reset && !timeout_s &&
                     (((state_r == IDLE) && mem_op_s) || (state_r == WAIT));
    assign stall_s = req_s && !MemAck;

    assign MemReq   = req_s;
    assign MemWe    = req_s && MemWriteM;
    assign MemAddr  = ALUResultM;
    assign MemByte  = Cant_ByteM;
    assign MemWData = Cant_ByteM ? zext_byte(WriteDataM) : WriteDataM;
    assign StallM   = stall_s;

    // Handshake FSM: park in WAIT until the memory acknowledges (or times out).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s && !MemAck) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (MemAck || timeout_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // M/W register: bubble while stalled or abandoned, otherwise take the M inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RDW        <= 5'd0;
            ALUResultW <= 19'd0;
            ReadDataW  <= 19'd0;
        end else if (stall_s || timeout_s) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RDW        <= 5'd0;
            ALUResultW <= 19'd0;
            ReadDataW  <= 19'd0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            if (!ResultSrcM) begin
                ReadDataW <= 19'd0;
            end else if (Cant_ByteM) begin
                ReadDataW <= zext_byte(MemRData);
            end else begin
                ReadDataW <= MemRData;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum number of wait cycles per access, used only when MEM_TIMEOUT_EN is defined.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, all flops rising-edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have ports RegWriteM, MemWriteM, ResultSrcM and Cant_ByteM, each input, 1 bit: control from execute, where ResultSrcM=1 means load and Cant_ByteM=1 means byte access and 0 means 19-bit word access.
REQ-005 The module SHALL have port RDM, input, 5 bits: destination register.
REQ-006 The module SHALL have ports ALUResultM and WriteDataM, each input, 19 bits: the address or ALU result, and the store data.
REQ-007 The module SHALL have ports MemReq and MemWe, each output, 1 bit: data-memory request and write strobe.
REQ-008 The module SHALL have ports MemAddr and MemWData, each output, 19 bits, and port MemByte, output, 1 bit: access address, store data and byte flag.
REQ-009 The module SHALL have port MemAck, input, 1 bit, and port MemRData, input, 19 bits: access completion and read data.
REQ-010 The module SHALL have port StallM, output, 1 bit: the upstream stages hold their state while it is high.
REQ-011 The module SHALL have ports RegWriteW and ResultSrcW, each output, 1 bit, port RDW, output, 5 bits, and ports ALUResultW and ReadDataW, each output, 19 bits: the M/W pipeline register.
REQ-012 The module SHALL have port MemErr, output, 1 bit: access-timeout pulse.

Function
REQ-013 A memory operation SHALL be defined as MemWriteM=1 or ResultSrcM=1; an operation with all three of RegWriteM, MemWriteM and ResultSrcM equal to 0 SHALL be treated as a bubble.
REQ-014 The FSM SHALL have two states, IDLE and WAIT: IDLE goes to WAIT on a memory operation with MemAck=0; WAIT goes to IDLE on MemAck=1 (or on timeout); every other case holds the current state.
REQ-015 MemReq SHALL be combinational and equal to (IDLE and memory operation) or WAIT.
REQ-016 MemWe SHALL equal MemReq and MemWriteM.
REQ-017 MemAddr SHALL equal ALUResultM.
REQ-018 MemByte SHALL equal Cant_ByteM.
REQ-019 MemWData SHALL equal WriteDataM for word access and {11'b0, WriteDataM[7:0]} for byte access.
REQ-020 StallM SHALL equal MemReq and not MemAck; a zero-wait access (MemAck already high in the request cycle) therefore causes no stall.
REQ-021 The M/W register SHALL load from the inputs on the rising edge where StallM=0.
REQ-022 ReadDataW SHALL capture MemRData for a word load, {11'b0, MemRData[7:0]} for a byte load, and 0 for a non-load.
REQ-023 While StallM=1, the M/W register SHALL load a bubble (RegWriteW=0, ResultSrcW=0, RDW=0), so writeback never repeats an instruction.
REQ-024 Latency from the inputs to the W outputs SHALL be 1 cycle plus the number of memory wait cycles.
REQ-025 The inputs SHALL be required to stay stable while StallM=1; the module SHALL NOT latch request fields.
REQ-026 MemAck received in IDLE without a memory operation SHALL be ignored.
REQ-027 A store SHALL produce RegWriteW as presented on RegWriteM, with no forced write.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, and all W outputs and MemErr SHALL reset to 0.
REQ-029 Reset asserted during WAIT SHALL drop MemReq and StallM in the same cycle (combinational from the state) and abandon the access without writeback.
REQ-030 The first access after reset deasserts SHALL start cleanly from IDLE.

Configuration
REQ-031 With MEM_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle without MemAck.
REQ-032 With MEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the module SHALL: pulse MemErr for 1 cycle, return to IDLE, deassert MemReq and StallM in that cycle, and load a bubble into the M/W register.
REQ-033 With MEM_TIMEOUT_EN defined, MemAck arriving in the same cycle as the timeout SHALL win, completing normally with MemErr=0.
REQ-034 With MEM_TIMEOUT_EN undefined, there SHALL be no counter, the module SHALL wait in WAIT indefinitely, and MemErr SHALL be constant 0.

Verification
REQ-035 A word load with ALUResultM=0x00010 and MemAck tied high SHALL give StallM=0 throughout and, next edge, ReadDataW=MemRData=0x5A5A5, RegWriteW=1 and ResultSrcW=1.
REQ-036 A byte load where MemAck arrives 3 cycles late and MemRData=0x7FF3C SHALL give StallM=1 for 3 cycles, 3 bubbles on W, then ReadDataW=0x0003C.
REQ-037 A byte store with WriteDataM=0x12345 SHALL give MemWe=1, MemByte=1 and MemWData=0x00045, with RegWriteW=0 after the access.
REQ-038 A non-memory op with RegWriteM=1, RDM=7 and ALUResultM=0x00ABC SHALL keep MemReq=0 and give RDW=7, ALUResultW=0x00ABC and ReadDataW=0 next cycle.
REQ-039 Reset asserted during the 2nd wait cycle SHALL drop MemReq and StallM immediately, clear the W outputs to 0, and leave the FSM in IDLE.
REQ-040 With MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4 and MemAck never asserted, MemErr SHALL pulse once after 4 wait cycles, StallM SHALL then fall, and W SHALL hold a bubble.
